// File: rtl/bist_pkg.sv
// bist_pkg: shared state encoding, LFSR/MISR constants and step functions for the serial BIST player
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET_CUT,
        APPLY,
        FLUSH,
        DONE
    } state_e;

    // Feedback taps 8,6,5,4 as a mask over lfsr[7:0]
    localparam logic [7:0]  LFSR_TAPS     = 8'hB8;
    localparam logic [15:0] MISR_POLY     = 16'h1021;
    // An all-zero LFSR never leaves zero, so a zero seed is replaced
    localparam logic [7:0]  SEED_FALLBACK = 8'h01;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [1:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ {14'b0, d};
    endfunction

endpackage

// File: rtl/misr16.sv
// misr16: 16-bit multiple-input signature register compacting a 2-bit response per enabled cycle
//   clk    - rising-edge clock
//   rst    - asynchronous active-low reset, clears the signature
//   clr_i  - synchronous clear to zero (wins over en_i)
//   en_i   - fold data_i into the signature this cycle
//   data_i - response bits {overflw, outp}
//   sig_o  - current signature
module misr16
    import bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [1:0]  data_i,
    output logic [15:0] sig_o
);

    logic [15:0] sig_q, sig_d;

    always_comb sig_d = clr_i ? 16'h0000 : (en_i ? misr_step(sig_q, data_i) : sig_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sig_q <= 16'h0000;
        else      sig_q <= sig_d;
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/bist_serial_player.sv
// bist_serial_player: LFSR-driven k/j stimulus generator with MISR response compaction for the serial comparator core
//   clk       - rising-edge clock
//   rst       - asynchronous active-low reset, aborts any run
//   start     - run request, sampled only in IDLE/DONE
//   k, j      - serial stimulus lines to the core
//   cut_rst   - active-high reset held on the core outside a run
//   outp      - core result output (response bit 0)
//   overflw   - core overflow output (response bit 1)
//   busy      - run in progress
//   done      - run complete, signature/pass valid
//   pass      - signature matched GOLDEN
//   signature - MISR contents
module bist_serial_player
    import bist_pkg::*;
#(
    parameter int unsigned N_PATTERNS = 10,
    parameter int unsigned RST_CYCLES = 2,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5,
    parameter logic [15:0] GOLDEN     = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        k,
    output logic        j,
    output logic        cut_rst,
    input  logic        outp,
    input  logic        overflw,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    localparam int unsigned CW = $clog2(N_PATTERNS > RST_CYCLES ? N_PATTERNS : RST_CYCLES) + 1;
    localparam logic [7:0]    SEED   = (LFSR_SEED == 8'h00) ? SEED_FALLBACK : LFSR_SEED;
    localparam logic [CW-1:0] N_LAST = CW'(N_PATTERNS - 1);
    localparam logic [CW-1:0] R_LAST = CW'(RST_CYCLES - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    lfsr_q;
    logic          k_q, j_q, cut_rst_q, busy_q, done_q, pass_q;
    logic          run_req, misr_clr, misr_en;
    logic [1:0]    resp;

    assign resp     = {overflw, outp};
    assign run_req  = start && (state_q == IDLE || state_q == DONE);
    assign misr_clr = run_req || state_q == RESET_CUT;
    // The core registers its outputs, so the response to pattern i arrives one
    // cycle late: skip the first APPLY cycle and pick up the last one in FLUSH.
    assign misr_en  = (state_q == APPLY && cnt_q != '0) || state_q == FLUSH;

    misr16 u_misr (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (misr_clr),
        .en_i   (misr_en),
        .data_i (resp),
        .sig_o  (signature)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lfsr_q    <= SEED;
            k_q       <= 1'b0;
            j_q       <= 1'b0;
            cut_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) begin
                    state_q   <= RESET_CUT;
                    cnt_q     <= '0;
                    lfsr_q    <= SEED;
                    k_q       <= 1'b0;
                    j_q       <= 1'b0;
                    cut_rst_q <= 1'b1;
                    busy_q    <= 1'b1;
                    done_q    <= 1'b0;
                    pass_q    <= 1'b0;
                end
                RESET_CUT: begin
                    if (cnt_q == R_LAST) begin
                        state_q   <= APPLY;
                        cnt_q     <= '0;
                        cut_rst_q <= 1'b0;
                        k_q       <= lfsr_q[1];
                        j_q       <= lfsr_q[0];
                        lfsr_q    <= lfsr_step(lfsr_q);
                    end else begin
                        cnt_q     <= cnt_q + CW'(1);
                    end
                end
                APPLY: begin
                    lfsr_q <= lfsr_step(lfsr_q);
                    if (cnt_q == N_LAST) begin
                        state_q <= FLUSH;
                        k_q     <= 1'b0;
                        j_q     <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                        k_q     <= lfsr_q[1];
                        j_q     <= lfsr_q[0];
                    end
                end
                FLUSH: begin
                    state_q   <= DONE;
                    cut_rst_q <= 1'b1;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    // Compare against the value the MISR takes on this same edge
                    pass_q    <= misr_step(signature, resp) == GOLDEN;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign k       = k_q;
    assign j       = j_q;
    assign cut_rst = cut_rst_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;

endmodule

// File: doc/bist_serial_player.md
# bist_serial_player

Self-test driver for the serial two-line comparator core (`circuito12`: inputs `k`, `j`; outputs `outp`, `overflw`). It generates the `k`/`j` vector stream that the simulation bench reads from `b01.vec`, using an on-chip LFSR instead of a file. It holds the core in reset and applies a fixed number of patterns. It compacts the core's responses into a MISR signature and flags pass/fail against a golden value. It sits beside the core as its synthesizable stimulus and response end.

## Interface
Parameters:
- `N_PATTERNS`, default 10: number of vectors applied per run (≥1).
- `RST_CYCLES`, default 2: cycles `cut_rst` is held before patterns start (≥1).
- `LFSR_SEED`, default 8'hA5: LFSR load value. A value of 0 is replaced by 8'h01.
- `GOLDEN`, default 16'h0000: expected final signature.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: run request, level-sampled in IDLE/DONE.
- `k`, out, 1: serial line 1 to the core.
- `j`, out, 1: serial line 2 to the core.
- `cut_rst`, out, 1: active-high reset to the core.
- `outp`, in, 1: core result output.
- `overflw`, in, 1: core overflow output.
- `busy`, out, 1: run in progress.
- `done`, out, 1: run complete; `signature` and `pass` are valid.
- `pass`, out, 1: `signature == GOLDEN`, valid while `done` is high.
- `signature`, out, 16: MISR contents.

## Operation
- States:
  - IDLE → RESET_CUT on `start`.
  - RESET_CUT → APPLY after `RST_CYCLES` cycles.
  - APPLY → FLUSH after `N_PATTERNS` cycles.
  - FLUSH → DONE after 1 cycle.
  - DONE → RESET_CUT on `start`; otherwise stays in DONE.
- Reset values (`rst`=0, immediate):
  - State IDLE.
  - `k`=`j`=0, `cut_rst`=1.
  - `busy`=`done`=`pass`=0, `signature`=0.
  - LFSR loaded with the seed.
- RESET_CUT:
  - `cut_rst`=1, `k`=`j`=0.
  - LFSR reloaded with the seed, MISR cleared to 0.
- APPLY:
  - `cut_rst`=0, `k`=lfsr[1], `j`=lfsr[0].
  - LFSR steps every cycle: lfsr ← {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- Response capture skew: the core's outputs are registered, so the response to pattern i is sampled one cycle later.
  - The MISR updates on APPLY cycles 1..N−1 and on the FLUSH cycle, giving exactly `N_PATTERNS` captures.
- MISR update: sig ← {sig[14:0],0} ^ (sig[15] ? 16'h1021 : 0) ^ {14'b0, overflw, outp}.
- FLUSH: `k`=`j`=0.
- DONE:
  - `done`=1, `busy`=0, `pass`=(sig==GOLDEN).
  - Signature held; core held in reset (`cut_rst`=1).
- `busy`=1 in RESET_CUT, APPLY and FLUSH.
- `start` is ignored while `busy`=1.
- `start` held high in DONE restarts immediately; `done` drops on the next edge.
- `rst` asserted mid-run aborts with no partial `done`.

## Timing
- All outputs are registered; none has a combinational path from any input.
- Edge numbering: edge 0 is the rising edge that samples `start`=1.
  - `busy` is high from edge 0.
  - `cut_rst` is high through edge `RST_CYCLES`−1.
  - The first pattern is on `k`/`j` after edge `RST_CYCLES`.
- `done` rises after edge `RST_CYCLES`+`N_PATTERNS`+1, which is edge 13 with defaults.
- The run-length counter is ⌈log2(max(N_PATTERNS, RST_CYCLES))⌉+1 bits wide and never wraps within a run.

## Structure
- `bist_pkg` holds:
  - the state enum (IDLE, RESET_CUT, APPLY, FLUSH, DONE);
  - the LFSR tap mask 8'hB8 (taps 8,6,5,4);
  - the MISR polynomial 16'h1021;
  - the seed-zero fallback 8'h01.
- Sub-module `misr16` provides clear, enable, a 2-bit data input and a 16-bit signature output.
- The LFSR and the FSM stay inline in `bist_serial_player`.

## Test plan
- Reset values: with `rst`=0, expect `cut_rst`=1, `k`=`j`=`busy`=`done`=`pass`=0 and `signature`=0.
- Default run with the core replaced by constant `outp`=`overflw`=0:
  - Pulse `start`.
  - `cut_rst` is high for 2 cycles.
  - First two patterns are (k,j)=(0,1) then (1,0).
  - `done` rises at edge 13; `signature`=16'h0000; `pass`=1.
- Real core with `GOLDEN`=16'h0000:
  - Run to `done` and record the signature.
  - Expect `pass`=0 unless the signature is 0.
  - Rerun with `GOLDEN` set to the recorded signature and expect `pass`=1 with an identical signature.
- `start` held high through DONE:
  - Expect `done` high for exactly 1 cycle.
  - The second run yields a signature identical to the first.
- Abort: assert `rst` during the 5th APPLY cycle.
  - Outputs return to reset values asynchronously.
  - The following run matches an uninterrupted run bit-for-bit.
- `LFSR_SEED`=0: the first patterns equal those of seed 8'h01, i.e. (k,j)=(0,1) then (1,0).
